// File: rtl/multi_counter_pkg.sv
// Shared constants and helpers for the multi-channel event counter bank.
package multi_counter_pkg;

  localparam int MODE_WRAP       = 0;
  localparam int MODE_SAT        = 1;
  localparam int DIV_RST_DEFAULT = 3;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel-select width; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/multi_counter_channel.sv
// One counter channel: prescaler, divide register, count and terminal-count pulse.
// With MULTI_COUNTER_SNAPSHOT_EN defined the next-state count is exported for snapshots.
module counter_channel
  import multi_counter_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int PRE_W    = 8,
  parameter int DIV_INIT = 0,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [PRE_W-1:0] cfg_div,
  output logic [WIDTH-1:0] count,
`ifdef MULTI_COUNTER_SNAPSHOT_EN
  output logic [WIDTH-1:0] count_nxt,
`endif
  output logic             tc
);

  localparam logic             SAT_MODE = (SATURATE == MODE_SAT);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             adv;

  // Next-state: prescale events, advance count, then let config and clear override.
  always_comb begin
    pre_d = pre_q;
    div_d = div_q;
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    adv   = 1'b0;

    if (hit) begin
      if (pre_q == div_q) begin
        pre_d = '0;
        adv   = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (adv) begin
      if (SAT_MODE) begin
        // Once at all-ones the count sticks and no further pulses are produced.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
          tc_d  = (cnt_q == CNT_MAX - 1'b1);
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        tc_d  = (cnt_q == CNT_MAX);
      end
    end

    // Event in the same cycle was judged against the old divide; prescaler restarts.
    if (cfg_we) begin
      div_d = cfg_div;
      pre_d = '0;
    end

    if (clr) begin
      cnt_d = '0;
      pre_d = '0;
      tc_d  = 1'b0;
    end
  end

  // Channel state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      div_q <= PRE_W'(DIV_INIT);
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign count = cnt_q;
  assign tc    = tc_q;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
  assign count_nxt = cnt_d;
`endif

endmodule

// File: rtl/multi_counter.sv
// Multi-channel event counter bank with per-channel prescaler, clear and Tc pulse.
// Optional snapshot register enabled by defining MULTI_COUNTER_SNAPSHOT_EN.
module multi_counter
  import multi_counter_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int NUM_CH   = 2,
  parameter  int PRE_W    = 8,
  parameter  int DIV_RST  = DIV_RST_DEFAULT,
  parameter  int SATURATE = MODE_WRAP,
  localparam int SEL_W    = sel_width(NUM_CH)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    En,
  input  logic [SEL_W-1:0]        Slt,
  input  logic [NUM_CH-1:0]       Clr,
  input  logic                    Cfg_We,
  input  logic [SEL_W-1:0]        Cfg_Ch,
  input  logic [PRE_W-1:0]        Cfg_Div,
  output logic [NUM_CH*WIDTH-1:0] Count,
  output logic [NUM_CH-1:0]       Tc
`ifdef MULTI_COUNTER_SNAPSHOT_EN
  ,
  input  logic                    Snap,
  output logic [NUM_CH*WIDTH-1:0] Snap_Count
`endif
);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] cfg_hit;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
  logic [NUM_CH*WIDTH-1:0] cnt_nxt;
  logic [NUM_CH*WIDTH-1:0] snap_q, snap_d;
`endif

  // Decode event and config selects; out-of-range selects match no channel.
  always_comb begin
    hit     = '0;
    cfg_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]     = En && (Slt == SEL_W'(i));
      cfg_hit[i] = Cfg_We && (Cfg_Ch == SEL_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH   (WIDTH),
      .PRE_W   (PRE_W),
      .DIV_INIT((i == 0) ? 0 : DIV_RST),
      .SATURATE(SATURATE)
    ) u_ch (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .hit      (hit[i]),
      .clr      (Clr[i]),
      .cfg_we   (cfg_hit[i]),
      .cfg_div  (Cfg_Div),
      .count    (Count[i*WIDTH +: WIDTH]),
`ifdef MULTI_COUNTER_SNAPSHOT_EN
      .count_nxt(cnt_nxt[i*WIDTH +: WIDTH]),
`endif
      .tc       (Tc[i])
    );
  end

`ifdef MULTI_COUNTER_SNAPSHOT_EN
  // Snapshot captures all channels' next-state counts in one edge.
  always_comb begin
    snap_d = snap_q;
    if (Snap) snap_d = cnt_nxt;
  end

  // Snapshot register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) snap_q <= '0;
    else          snap_q <= snap_d;
  end

  assign Snap_Count = snap_q;
`endif

endmodule

// File: tb/tb_multi_counter.sv
// Directed bench for multi_counter: three instances (default, 3ch wrap W=4, saturating W=4).
module tb_multi_counter;

  localparam int DA = 0, DW = 1, DS = 2;
  localparam int KC = 0, KT = 1, KS = 2;

  typedef struct {
    string       tag;
    int          dut;
    int          kind;
    int          ch;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults (WIDTH=64, NUM_CH=2)
  logic         en_a, cfgwe_a;
  logic [0:0]   slt_a, cfgch_a;
  logic [1:0]   clr_a, tc_a;
  logic [7:0]   cfgdiv_a;
  logic [127:0] cnt_a;
  // Instance W: WIDTH=4, NUM_CH=3, wrap
  logic         en_w, cfgwe_w;
  logic [1:0]   slt_w, cfgch_w;
  logic [2:0]   clr_w, tc_w;
  logic [7:0]   cfgdiv_w;
  logic [11:0]  cnt_w;
  // Instance S: WIDTH=4, NUM_CH=2, saturate
  logic         en_s, cfgwe_s;
  logic [0:0]   slt_s, cfgch_s;
  logic [1:0]   clr_s, tc_s;
  logic [7:0]   cfgdiv_s;
  logic [7:0]   cnt_s;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
  logic         snap_a, snap_ws;
  logic [127:0] snapc_a;
  logic [11:0]  snapc_w;
  logic [7:0]   snapc_s;
`endif

  multi_counter u_a (
    .Clk(clk), .Reset_n(rst_n), .En(en_a), .Slt(slt_a), .Clr(clr_a),
    .Cfg_We(cfgwe_a), .Cfg_Ch(cfgch_a), .Cfg_Div(cfgdiv_a),
    .Count(cnt_a), .Tc(tc_a)
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    , .Snap(snap_a), .Snap_Count(snapc_a)
`endif
  );

  multi_counter #(.WIDTH(4), .NUM_CH(3)) u_w (
    .Clk(clk), .Reset_n(rst_n), .En(en_w), .Slt(slt_w), .Clr(clr_w),
    .Cfg_We(cfgwe_w), .Cfg_Ch(cfgch_w), .Cfg_Div(cfgdiv_w),
    .Count(cnt_w), .Tc(tc_w)
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    , .Snap(snap_ws), .Snap_Count(snapc_w)
`endif
  );

  multi_counter #(.WIDTH(4), .NUM_CH(2), .SATURATE(1)) u_s (
    .Clk(clk), .Reset_n(rst_n), .En(en_s), .Slt(slt_s), .Clr(clr_s),
    .Cfg_We(cfgwe_s), .Cfg_Ch(cfgch_s), .Cfg_Div(cfgdiv_s),
    .Count(cnt_s), .Tc(tc_s)
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    , .Snap(snap_ws), .Snap_Count(snapc_s)
`endif
  );

  function automatic logic [63:0] actual(input int dut, input int kind, input int ch);
    logic [63:0] v;
    v = '0;
    case (dut)
      DA: begin
        if (kind == KC)      v = cnt_a[ch*64 +: 64];
        else if (kind == KT) v = 64'(tc_a[ch]);
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        else                 v = snapc_a[ch*64 +: 64];
`endif
      end
      DW: begin
        if (kind == KC)      v = 64'(cnt_w[ch*4 +: 4]);
        else if (kind == KT) v = 64'(tc_w[ch]);
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        else                 v = 64'(snapc_w[ch*4 +: 4]);
`endif
      end
      default: begin
        if (kind == KC)      v = 64'(cnt_s[ch*4 +: 4]);
        else if (kind == KT) v = 64'(tc_s[ch]);
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        else                 v = 64'(snapc_s[ch*4 +: 4]);
`endif
      end
    endcase
    return v;
  endfunction

  task automatic ex(input string tag, input int dut, input int kind, input int ch,
                    input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.dut = dut; e.kind = kind; e.ch = ch; e.exp = val;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = actual(e.dut, e.kind, e.ch);
      n_checks++;
      assert (act === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s dut=%0d ch=%0d observed=%0h expected=%0h",
               e.tag, e.dut, e.ch, act, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 0; slt_a = 0; clr_a = 0; cfgwe_a = 0; cfgch_a = 0; cfgdiv_a = 0;
    en_w = 0; slt_w = 0; clr_w = 0; cfgwe_w = 0; cfgch_w = 0; cfgdiv_w = 0;
    en_s = 0; slt_s = 0; clr_s = 0; cfgwe_s = 0; cfgch_s = 0; cfgdiv_s = 0;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    snap_a = 0; snap_ws = 0;
`endif

    // Reset state
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      ex("rst_cnt_a", DA, KC, c, 0); ex("rst_tc_a", DA, KT, c, 0);
      ex("rst_cnt_s", DS, KC, c, 0); ex("rst_tc_s", DS, KT, c, 0);
    end
    for (int c = 0; c < 3; c++) begin
      ex("rst_cnt_w", DW, KC, c, 0); ex("rst_tc_w", DW, KT, c, 0);
    end
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    ex("rst_snap_a", DA, KS, 0, 0); ex("rst_snap_w", DW, KS, 2, 0);
    ex("rst_snap_s", DS, KS, 1, 0);
`endif
    drain();
    rst_n = 1'b1;

    // Default divides: ch0 counts every event, ch1 every 4th
    en_a = 1; slt_a = 0;
    for (int k = 1; k <= 8; k++) begin ex("div0_c0", DA, KC, 0, 64'(k)); tick(); end
    slt_a = 1;
    for (int k = 1; k <= 8; k++) begin ex("div3_c1", DA, KC, 1, 64'(k / 4)); tick(); end
    en_a = 0;
    ex("hold_c0", DA, KC, 0, 8); ex("hold_tc0", DA, KT, 0, 0); ex("hold_tc1", DA, KT, 1, 0);
    tick();

    // Reprogram ch1 divide mid-stream with a simultaneous event
    en_a = 1; slt_a = 1;
    for (int k = 1; k <= 2; k++) begin ex("pre_c1", DA, KC, 1, 2); tick(); end
    cfgwe_a = 1; cfgch_a = 1; cfgdiv_a = 0;
    ex("cfg_evt_c1", DA, KC, 1, 2); tick();
    cfgwe_a = 0;
    for (int k = 1; k <= 3; k++) begin ex("newdiv_c1", DA, KC, 1, 64'(2 + k)); tick(); end

    // Clear beats event; other channel untouched; prescaler cleared
    clr_a = 2'b10;
    ex("clr_c1", DA, KC, 1, 0); ex("clr_c0", DA, KC, 0, 8); ex("clr_tc1", DA, KT, 1, 0);
    tick();
    clr_a = 0;
    ex("post_clr_c1", DA, KC, 1, 1); tick();

    // Config on ch0 while pre==div: count still advances, prescaler restarts at new div
    slt_a = 0; cfgwe_a = 1; cfgch_a = 0; cfgdiv_a = 1;
    ex("cfg_adv_c0", DA, KC, 0, 9); tick();
    cfgwe_a = 0;
    ex("div1_a_c0", DA, KC, 0, 9); tick();
    ex("div1_b_c0", DA, KC, 0, 10); tick();
    ex("div1_c_c0", DA, KC, 0, 10); tick();
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    snap_a = 1;
    ex("snap_c0", DA, KS, 0, 11); ex("snap_c1", DA, KS, 1, 1);
`endif
    ex("div1_d_c0", DA, KC, 0, 11); tick();
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    snap_a = 0;
    ex("snap_hold_c0", DA, KS, 0, 11);
`endif
    ex("div1_e_c0", DA, KC, 0, 11); tick();
    en_a = 0;

    // Asynchronous reset mid-count, checked before the next edge
    #2 rst_n = 1'b0;
    #1;
    ex("arst_c0", DA, KC, 0, 0); ex("arst_c1", DA, KC, 1, 0);
    ex("arst_tc0", DA, KT, 0, 0); ex("arst_tc1", DA, KT, 1, 0);
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    ex("arst_snap0", DA, KS, 0, 0);
`endif
    drain();
    @(negedge clk) rst_n = 1'b1;
    en_a = 1; slt_a = 1;
    for (int k = 1; k <= 4; k++) begin ex("rediv_c1", DA, KC, 1, 64'(k / 4)); tick(); end
    slt_a = 0;
    ex("rediv_c0", DA, KC, 0, 1); tick();
    en_a = 0;

    // Wrap on WIDTH=4: Tc aligned with count returning to 0
    en_w = 1; slt_w = 0;
    for (int k = 1; k <= 16; k++) begin
      ex("wrap_c0", DW, KC, 0, 64'(k % 16)); ex("wrap_tc0", DW, KT, 0, 64'(k == 16));
      tick();
    end
    ex("wrap_next_c0", DW, KC, 0, 1); ex("wrap_next_tc0", DW, KT, 0, 0); tick();

    // Out-of-range event select and config channel
    slt_w = 3; cfgwe_w = 1; cfgch_w = 3; cfgdiv_w = 0;
    for (int k = 0; k < 2; k++) begin
      ex("oor_c0", DW, KC, 0, 1); ex("oor_c1", DW, KC, 1, 0); ex("oor_c2", DW, KC, 2, 0);
      ex("oor_tc", DW, KT, 0, 0);
      tick();
    end
    cfgwe_w = 0; slt_w = 2;
    for (int k = 1; k <= 4; k++) begin ex("oor_div_c2", DW, KC, 2, 64'(k / 4)); tick(); end

    // Pending Tc discarded by asynchronous reset
    slt_w = 0;
    for (int k = 1; k <= 14; k++) tick();
    ex("pre_wrap_c0", DW, KC, 0, 15); drain();
    ex("wrap2_c0", DW, KC, 0, 0); ex("wrap2_tc0", DW, KT, 0, 1); tick();
    en_w = 0;
    #2 rst_n = 1'b0;
    #1;
    ex("arst_w_tc0", DW, KT, 0, 0); ex("arst_w_c2", DW, KC, 2, 0);
    drain();
    @(negedge clk) rst_n = 1'b1;

    // Saturation on WIDTH=4: stick at 15, single Tc
    en_s = 1; slt_s = 0;
    for (int k = 1; k <= 20; k++) begin
      ex("sat_c0", DS, KC, 0, 64'((k < 15) ? k : 15)); ex("sat_tc0", DS, KT, 0, 64'(k == 15));
      tick();
    end
    ex("sat_c1", DS, KC, 1, 0); drain();

    // Clear plus config on the same channel in one cycle
    clr_s = 2'b01; cfgwe_s = 1; cfgch_s = 0; cfgdiv_s = 1;
    ex("clrcfg_c0", DS, KC, 0, 0); ex("clrcfg_tc0", DS, KT, 0, 0); tick();
    clr_s = 0; cfgwe_s = 0;
    for (int k = 1; k <= 4; k++) begin ex("clrcfg_div_c0", DS, KC, 0, 64'(k / 2)); tick(); end
    en_s = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
